axi_lite_lsu_master: RTL and testbench
======================================

# axi_lite_lsu_master

AXI4-Lite initiator connecting the core's load/store unit to the memory/device bus. It accepts one simple request at a time (a load or a store with a byte mask) and runs the matching AXI4-Lite read (AR/R) or write (AW/W/B) transaction. It then returns lane-aligned read data and an error flag to the core. It is the initiator side of the bus whose responder is the randomized-delay memory model. It also keeps wrapping completed-transaction counters for performance reporting.

## Interface
- No parameters; data and address are fixed at 32 bits, strobe at 4 bits.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: asserting `rst` low immediately forces reset state.
- req_valid  in  1  core request valid.
- req_ready  out  1  block can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned at bit 0.
- req_wmask  in  4  store byte mask, right-aligned.
- resp_valid / resp_ready  out / in  1  response handshake to core.
- resp_rdata  out  32  load data, right-aligned; 0 for stores.
- resp_err  out  1  bus returned a nonzero RRESP/BRESP.
- araddr out 32; arvalid out 1; arready in 1  AR channel.
- rdata in 32; rresp in 2; rvalid in 1; rready out 1  R channel.
- awaddr out 32; awvalid out 1; awready in 1  AW channel.
- wdata out 32; wstrb out 4; wvalid out 1; wready in 1  W channel.
- bresp in 2; bvalid in 1; bready out 1  B channel.
- rd_cnt, wr_cnt  out  32  completed load/store counts.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- req_ready = (state == IDLE).
- Request is accepted on req_valid & req_ready. On acceptance, latch addr, wen, wdata, mask and the byte offset off = addr[1:0].
- Load path: IDLE → RD_ADDR.
  - In RD_ADDR: arvalid = 1 and araddr = latched addr (unaligned addresses are passed through).
  - On arvalid & arready → RD_DATA.
  - In RD_DATA: rready = 1. On rvalid fire, capture resp_rdata = rdata >> (8·off) (zero-filled) and resp_err = (rresp != 0), then → RESP.
- Store path: IDLE → WR_REQ.
  - awaddr = latched addr.
  - wdata = (req_wdata << 8·off), truncated to 32 bits.
  - wstrb = (req_wmask << off), truncated to 4 bits.
  - awvalid and wvalid are asserted together. Each drops independently after its own handshake, tracked by aw_done and w_done flags.
  - When both are done, including the case where both fire in the same cycle → WR_RESP.
  - In WR_RESP: bready = 1. On bvalid fire, resp_err = (bresp != 0) and resp_rdata = 0, then → RESP.
- RESP: resp_valid = 1 and response fields are held stable.
  - On resp_ready → IDLE.
  - On the same edge, increment rd_cnt (loads) or wr_cnt (stores). Errored transactions are also counted.
- Counters wrap: 0xFFFF_FFFF + 1 → 0.
- R/B beats arriving outside RD_DATA/WR_RESP are not accepted (rready/bready = 0).
- AXI stability: while a valid is high without its ready, its address/data/strobe must not change. All channel outputs come from latched registers, never from req_*.

## Timing
- Reset values: state IDLE; arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err = 0; araddr, awaddr, wdata, resp_rdata = 0; wstrb = 0; rd_cnt = wr_cnt = 0; req_ready = 1.
- All AXI and response outputs are registered or decoded from state only. There is no combinational path from any *ready/*valid input to any output.
- Load, zero-wait responder:
  - Request accepted at edge N.
  - arvalid high from N+1 to N+2; AR fires at N+2.
  - rready high from N+2 to N+3; R fires at N+3.
  - resp_valid high from N+3.
- Store, zero-wait responder: AW and W fire at N+2, bready from N+2, B fires at N+3, resp_valid from N+3.
- Back-to-back requests: req_ready returns one cycle after the resp fire edge. There is no same-cycle bypass.
- Responder stalls of any length (e.g., 0–15 cycles of delay) simply extend RD_DATA/WR_RESP. There is no timeout.
- Reset asserted mid-transaction: all valids drop immediately and state returns to IDLE. The in-flight transaction and counters are discarded.

## Test plan
- Load at 0x8000_0002 against a responder returning rdata 0xAABBCCDD, rresp 0 → araddr 0x8000_0002, resp_rdata 0x0000AABB, resp_err 0, rd_cnt 1.
- Store at 0x8000_0001, wdata 0x0000_1234, mask 0x3 → wdata 0x0012_3400, wstrb 0x6; AW and W held until both fire; wr_cnt 1.
- AW ready 3 cycles before W ready → awvalid drops the cycle after the AW fire; wvalid held with stable data until W fires; then a single B is accepted.
- B returns bresp 2'b10 → resp_err 1, resp_rdata 0; after resp_ready, req_ready returns to 1.
- Responder with 15-cycle R delay and resp_ready low for 4 cycles → resp_valid and resp_rdata are stable throughout; no new AR is issued before resp fires.
- Preload rd_cnt to 0xFFFF_FFFF via a forced value and complete one load → rd_cnt 0. Separately, assert `rst` low during WR_RESP → all valids 0 immediately and req_ready 1 after release.

Source files
------------

// File: rtl/axi_lite_lsu_master.sv
// AXI4-Lite initiator for the load/store unit: one request in flight, load -> AR/R, store -> AW/W/B.
// Latency: 3 cycles accept-to-response with a zero-wait responder; stalls on any AXI ready/valid or resp_ready_i.
module axi_lite_lsu_master (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wmask_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state_q;
  logic        wen_q;
  logic [1:0]  off_q;
  logic [31:0] araddr_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  logic aw_fire;
  logic w_fire;

  assign aw_fire = awvalid_q & awready_i;
  assign w_fire  = wvalid_q & wready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      off_q        <= 2'd0;
      araddr_q     <= 32'd0;
      awaddr_q     <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      rd_cnt_q     <= 32'd0;
      wr_cnt_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            wen_q <= req_wen_i;
            off_q <= req_addr_i[1:0];
            if (req_wen_i) begin
              awaddr_q  <= req_addr_i;
              wdata_q   <= req_wdata_i << {req_addr_i[1:0], 3'b000};
              wstrb_q   <= req_wmask_i << req_addr_i[1:0];
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_REQ;
            end else begin
              araddr_q <= req_addr_i;
              state_q  <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (!arvalid_q) begin
            arvalid_q <= 1'b1;
          end else if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid_i) begin
            rready_q     <= 1'b0;
            resp_rdata_q <= rdata_i >> {off_q, 3'b000};
            resp_err_q   <= |rresp_i;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        WR_REQ: begin
          // First cycle in WR_REQ raises both valids; afterwards each retires on its own handshake.
          if (!aw_done_q && !w_done_q && !awvalid_q && !wvalid_q) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
          end else begin
            if (aw_fire) begin
              awvalid_q <= 1'b0;
              aw_done_q <= 1'b1;
            end
            if (w_fire) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end
            if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
              bready_q <= 1'b1;
              state_q  <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            bready_q     <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= |bresp_i;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
            if (wen_q) wr_cnt_q <= wr_cnt_q + 32'd1;
            else       rd_cnt_q <= rd_cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign araddr_o     = araddr_q;
  assign arvalid_o    = arvalid_q;
  assign rready_o     = rready_q;
  assign awaddr_o     = awaddr_q;
  assign awvalid_o    = awvalid_q;
  assign wdata_o      = wdata_q;
  assign wstrb_o      = wstrb_q;
  assign wvalid_o     = wvalid_q;
  assign bready_o     = bready_q;
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_axi_lite_lsu_master.sv
// Directed and randomized bench for axi_lite_lsu_master; the bench plays the AXI responder and the core.
module tb_axi_lite_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic [31:0] rd_cnt, wr_cnt;

  int compared = 0;
  int failed   = 0;
  logic [31:0] rd_exp = 32'd0;
  logic [31:0] wr_exp = 32'd0;

  always #5 clk = ~clk;

  axi_lite_lsu_master dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_req(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] mask);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = mask;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
  endtask

  task automatic finish_resp(input logic [31:0] exp_rd, input logic exp_err, input int resp_dly);
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    for (int i = 0; i < resp_dly; i++) begin
      @(negedge clk);
      chk("resp_hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_hold_rdata", resp_rdata, exp_rd);
      chk("no_new_ar", {31'd0, arvalid}, 32'd0);
      chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_dropped", {31'd0, resp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] rdv, input logic [1:0] rr,
                         input int ar_dly, input int r_dly, input int resp_dly, input logic lat);
    logic [31:0] exp_rd;
    int n;
    exp_rd = rdv >> (8 * addr[1:0]);
    issue_req(1'b0, addr, $urandom, 4'($urandom));
    n = 0;
    while (arvalid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    chk("ar_seen", {31'd0, arvalid}, 32'd1);
    if (lat) chk("ar_latency", n, 32'd1);
    for (int i = 0; i < ar_dly; i++) begin
      chk("ar_hold_valid", {31'd0, arvalid}, 32'd1);
      chk("ar_hold_addr", araddr, addr);
      @(negedge clk);
    end
    chk("araddr", araddr, addr);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("ar_drop", {31'd0, arvalid}, 32'd0);
    chk("rready_on", {31'd0, rready}, 32'd1);
    for (int i = 0; i < r_dly; i++) begin
      chk("r_wait_rready", {31'd0, rready}, 32'd1);
      chk("r_wait_noresp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    rvalid = 1'b1; rdata = rdv; rresp = rr;
    @(negedge clk);
    rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
    chk("rready_off", {31'd0, rready}, 32'd0);
    finish_resp(exp_rd, rr != 2'b00, resp_dly);
    rd_exp = rd_exp + 32'd1;
    chk("rd_cnt", rd_cnt, rd_exp);
    chk("wr_cnt_idle", wr_cnt, wr_exp);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mask,
                          input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] br,
                          input int resp_dly, input logic lat, input logic rst_mid);
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    logic        aw_ok, w_ok;
    int n;
    exp_wd = wd << (8 * addr[1:0]);
    exp_st = mask << addr[1:0];
    issue_req(1'b1, addr, wd, mask);
    n = 0;
    while (awvalid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    chk("aw_seen", {31'd0, awvalid}, 32'd1);
    chk("w_with_aw", {31'd0, wvalid}, 32'd1);
    if (lat) chk("aw_latency", n, 32'd1);
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 40) begin
      if (!aw_ok) begin
        chk("aw_valid_hold", {31'd0, awvalid}, 32'd1);
        chk("awaddr", awaddr, addr);
      end else chk("aw_dropped", {31'd0, awvalid}, 32'd0);
      if (!w_ok) begin
        chk("w_valid_hold", {31'd0, wvalid}, 32'd1);
        chk("wdata", wdata, exp_wd);
        chk("wstrb", {28'd0, wstrb}, {28'd0, exp_st});
      end else chk("w_dropped", {31'd0, wvalid}, 32'd0);
      chk("bready_early", {31'd0, bready}, 32'd0);
      awready = !aw_ok && (n >= aw_dly);
      wready  = !w_ok && (n >= w_dly);
      @(negedge clk);
      if (awready) aw_ok = 1'b1;
      if (wready)  w_ok = 1'b1;
      awready = 1'b0; wready = 1'b0;
      n++;
    end
    chk("aw_w_done", {30'd0, aw_ok, w_ok}, 32'd3);
    chk("bready_on", {31'd0, bready}, 32'd1);
    chk("aw_off", {31'd0, awvalid}, 32'd0);
    chk("w_off", {31'd0, wvalid}, 32'd0);
    if (rst_mid) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      rd_exp = 32'd0; wr_exp = 32'd0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_rd_cnt", rd_cnt, rd_exp);
      chk("post_rst_wr_cnt", wr_cnt, wr_exp);
    end else begin
      for (int i = 0; i < b_dly; i++) begin
        chk("b_wait_bready", {31'd0, bready}, 32'd1);
        @(negedge clk);
      end
      bvalid = 1'b1; bresp = br;
      @(negedge clk);
      bvalid = 1'b0; bresp = 2'($urandom);
      chk("single_b", {31'd0, bready}, 32'd0);
      finish_resp(32'd0, br != 2'b00, resp_dly);
      wr_exp = wr_exp + 32'd1;
      chk("wr_cnt", wr_cnt, wr_exp);
      chk("rd_cnt_idle", rd_cnt, rd_exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    #12;
    chk("rst_req_ready0", {31'd0, req_ready}, 32'd1);
    chk("rst_valids0", {26'd0, arvalid, rready, awvalid, wvalid, bready, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_addrs", araddr | awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_cnts", rd_cnt | wr_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_load(32'h8000_0002, 32'hAABB_CCDD, 2'b00, 0, 0, 0, 1'b1);
    do_store(32'h8000_0001, 32'h0000_1234, 4'h3, 0, 0, 0, 2'b00, 0, 1'b1, 1'b0);
    do_store(32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 0, 3, 1, 2'b00, 0, 1'b0, 1'b0);
    do_store(32'h2000_0003, 32'h0000_00A5, 4'h1, 2, 0, 2, 2'b10, 1, 1'b0, 1'b0);
    do_load(32'h3000_0001, 32'h1122_3344, 2'b00, 1, 15, 4, 1'b0);
    do_load(32'h3000_0004, 32'h5566_7788, 2'b11, 0, 0, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      logic [1:0] rsp;
      rsp = ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      if ($urandom_range(1) == 1)
        do_store($urandom, $urandom, 4'($urandom), $urandom_range(4), $urandom_range(4),
                 $urandom_range(15), rsp, $urandom_range(3), 1'b0, 1'b0);
      else
        do_load($urandom, $urandom, rsp, $urandom_range(4), $urandom_range(15),
                $urandom_range(3), 1'b0);
    end

    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.rd_cnt_q;
    rd_exp = 32'hFFFF_FFFF;
    chk("rd_cnt_preload", rd_cnt, rd_exp);
    do_load(32'h4000_0000, 32'hCAFE_F00D, 2'b00, 0, 2, 0, 1'b0);
    chk("rd_cnt_wrapped", rd_cnt, 32'd0);

    do_store(32'h5000_0002, 32'h0000_BEEF, 4'h3, 1, 0, 8, 2'b00, 0, 1'b0, 1'b1);
    do_load(32'h6000_0003, 32'h8899_AABB, 2'b00, 0, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
